freq_gate_counter: RTL and testbench

FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

---
 rtl/freq_gate_counter.sv | 164 ++++++++++++++++
 tb/tb_freq_gate_counter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : freq_gate_counter                                          |
// | Description : Gated frequency counter. Counts rising edges of an         |
// |               asynchronous signal during each high window of a gate      |
// |               and publishes the result as packed BCD.                    |
// |                                                                          |
// | Parameters  : DIGITS   number of BCD digits in the result (1..8)         |
// |                                                                          |
// | Ports       : sys_clk  system clock, all state moves on its rising edge  |
// |               reset    asynchronous active-low reset                     |
// |               c_clk    gate, synchronous to sys_clk, high = window open  |
// |               sig_in   signal under test, asynchronous to sys_clk        |
// |               freq_bcd last completed count, digit 0 in bits [3:0]       |
// |               valid    one-cycle pulse when freq_bcd is updated          |
// |               ovf      last completed window saturated the BCD range     |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module freq_gate_counter #(
   parameter int DIGITS = 8
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   input  logic                  c_clk,
   input  logic                  sig_in,
   output logic [4*DIGITS-1:0]   freq_bcd,
   output logic                  valid,
   output logic                  ovf
);

   localparam int W = 4 * DIGITS;

   localparam logic [1:0] ST_WAIT_LOW = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;
   localparam logic [1:0] ST_COUNT    = 2'd2;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic s1;
   logic s2;
   logic s3;
   logic gate_r;

   logic sig_rise;
   logic gate_rise;
   logic gate_fall;

   // s1/s2 resolve metastability on the asynchronous input; s3 is only a
   // history flop so the edge detect works on settled values.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         gate_r <= 1'b0;
      end else begin
         s1     <= sig_in;
         s2     <= s1;
         s3     <= s2;
         gate_r <= c_clk;
      end
   end

   assign sig_rise  = s2 & ~s3;
   // The gate is already synchronous, so its edges are taken against the
   // live input to avoid adding a cycle of window latency.
   assign gate_rise = c_clk & ~gate_r;
   assign gate_fall = ~c_clk & gate_r;

   // ------------------------------------------------------------------
   // BCD incrementer: ripple carry across digits
   // ------------------------------------------------------------------
   logic [1:0]    state;
   logic [W-1:0]  count;
   logic [W-1:0]  count_inc;
   logic [W-1:0]  count_next;
   logic          ovf_int;
   logic          ovf_next;
   logic          all_nines;
   logic [DIGITS:0] carry;

   // carry[0] is the +1 being added; carry[i+1] reaches digit i+1 only when
   // every digit below it is 9.
   assign carry[0] = 1'b1;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         logic [3:0] digit;
         assign digit = count[4*i +: 4];
         assign count_inc[4*i +: 4] = !carry[i]          ? digit :
                                      (digit == 4'd9)    ? 4'd0  :
                                                           digit + 4'd1;
         assign carry[i+1] = carry[i] & (digit == 4'd9);
      end
   endgenerate

   // A carry out of the top digit means the counter is all 9s; in that case
   // the count is frozen and the overflow flag records the lost edge.
   assign all_nines = carry[DIGITS];

   always_comb begin
      count_next = count;
      ovf_next   = ovf_int;
      if (sig_rise) begin
         if (all_nines) begin
            ovf_next = 1'b1;
         end else begin
            count_next = count_inc;
         end
      end
   end

   // ------------------------------------------------------------------
   // Window control and result registers
   // ------------------------------------------------------------------
   // WAIT_LOW exists so that a window already open when reset is released is
   // never measured: the gate must be seen low before arming.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_WAIT_LOW;
         count    <= '0;
         ovf_int  <= 1'b0;
         freq_bcd <= '0;
         ovf      <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_WAIT_LOW: begin
               if (!c_clk) begin
                  state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (gate_rise) begin
                  state   <= ST_COUNT;
                  count   <= '0;
                  ovf_int <= 1'b0;
               end
            end
            ST_COUNT: begin
               count   <= count_next;
               ovf_int <= ovf_next;
               // Publish count_next rather than count so an edge landing in
               // the closing cycle is still included in the result.
               if (gate_fall) begin
                  state    <= ST_ARMED;
                  freq_bcd <= count_next;
                  ovf      <= ovf_next;
                  valid    <= 1'b1;
               end
            end
            default: begin
               state <= ST_WAIT_LOW;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_freq_gate_counter                                       |
// | Description : Self-checking bench for freq_gate_counter. Two instances   |
// |               (8 and 2 digits) share the stimulus; a behavioural model   |
// |               counts edges as an integer and derives the saturated BCD   |
// |               result for each width.                                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_freq_gate_counter;

   logic        sys_clk;
   logic        reset;
   logic        c_clk;
   logic        sig_in;
   logic [31:0] freq8;
   logic        valid8;
   logic        ovf8;
   logic [7:0]  freq2;
   logic        valid2;
   logic        ovf2;

   int n_vec;
   int n_err;
   int n_valid;

   freq_gate_counter #(.DIGITS(8)) dut8 (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .c_clk    (c_clk),
      .sig_in   (sig_in),
      .freq_bcd (freq8),
      .valid    (valid8),
      .ovf      (ovf8)
   );

   freq_gate_counter #(.DIGITS(2)) dut2 (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .c_clk    (c_clk),
      .sig_in   (sig_in),
      .freq_bcd (freq2),
      .valid    (valid2),
      .ovf      (ovf2)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic longint cap_of(input int digits);
      longint c;
      c = 1;
      for (int i = 0; i < digits; i++) c = c * 10;
      return c - 1;
   endfunction

   function automatic logic [31:0] to_bcd(input longint v, input int digits);
      logic [31:0] r;
      longint      x;
      r = '0;
      x = (v > cap_of(digits)) ? cap_of(digits) : v;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic bcd_ok(input logic [31:0] x);
      for (int i = 0; i < 8; i++) begin
         if (x[4*i +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   // ------------------------------------------------------------------
   // Behavioural model: edges are counted as a plain integer per window;
   // the published value is that integer clipped to the digit range.
   // ------------------------------------------------------------------
   logic [2:0]  m_hist;      // sig_in as sampled on the last three edges
   logic        m_gate_prev;
   int          m_phase;     // 0 wait for gate low, 1 armed, 2 counting
   int          m_count;
   logic [31:0] exp8;
   logic        exp_o8;
   logic [7:0]  exp2;
   logic        exp_o2;
   logic        exp_v;
   logic        m_rise;
   int          m_total;

   // An input edge is seen once it has been sampled twice and the sample
   // before it was low.
   assign m_rise  = m_hist[1] & ~m_hist[2];
   assign m_total = m_count + int'(m_rise);

   always @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         m_hist      <= '0;
         m_gate_prev <= 1'b0;
         m_phase     <= 0;
         m_count     <= 0;
         exp8        <= '0;
         exp_o8      <= 1'b0;
         exp2        <= '0;
         exp_o2      <= 1'b0;
         exp_v       <= 1'b0;
      end else begin
         m_hist      <= {m_hist[1:0], sig_in};
         m_gate_prev <= c_clk;
         exp_v       <= 1'b0;
         if (m_phase == 0) begin
            if (!c_clk) m_phase <= 1;
         end else if (m_phase == 1) begin
            if (c_clk && !m_gate_prev) begin
               m_phase <= 2;
               m_count <= 0;
            end
         end else begin
            m_count <= m_total;
            if (!c_clk && m_gate_prev) begin
               m_phase <= 1;
               exp8    <= to_bcd(longint'(m_total), 8);
               exp_o8  <= longint'(m_total) > cap_of(8);
               exp2    <= 8'(to_bcd(longint'(m_total), 2));
               exp_o2  <= longint'(m_total) > cap_of(2);
               exp_v   <= 1'b1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge sys_clk) begin
      chk("freq8",   freq8,          exp8);
      chk("ovf8",    32'(ovf8),      32'(exp_o8));
      chk("valid8",  32'(valid8),    32'(exp_v));
      chk("freq2",   32'(freq2),     32'(exp2));
      chk("ovf2",    32'(ovf2),      32'(exp_o2));
      chk("valid2",  32'(valid2),    32'(exp_v));
      chk("digits8", 32'(bcd_ok(freq8)), 32'd1);
      if (valid8) n_valid <= n_valid + 1;
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         sig_in = 1'b1;
         idle(5);
         sig_in = 1'b0;
         idle(5);
      end
   endtask

   task automatic wait_result(input string name, input logic [31:0] e8, input logic eo8,
                              input logic [7:0] e2, input logic eo2);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         @(negedge sys_clk);
         #1;
         if (valid8) found = 1'b1;
      end
      chk({name, "_valid_seen"}, 32'(found), 32'd1);
      chk({name, "_bcd8"}, freq8, e8);
      chk({name, "_ovf8"}, 32'(ovf8), 32'(eo8));
      chk({name, "_bcd2"}, 32'(freq2), 32'(e2));
      chk({name, "_ovf2"}, 32'(ovf2), 32'(eo2));
   endtask

   task automatic window(input string name, input int n, input logic [31:0] e8, input logic eo8,
                         input logic [7:0] e2, input logic eo2);
      idle(1);
      c_clk = 1'b1;
      pulses(n);
      c_clk = 1'b0;
      wait_result(name, e8, eo8, e2, eo2);
      idle(10);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      n_vec   = 0;
      n_err   = 0;
      n_valid = 0;
      reset   = 1'b1;
      c_clk   = 1'b1;
      sig_in  = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("rst_freq8",  freq8,        32'd0);
      chk("rst_ovf8",   32'(ovf8),    32'd0);
      chk("rst_valid8", 32'(valid8),  32'd0);
      chk("rst_freq2",  32'(freq2),   32'd0);

      // Reset released inside an open window with sig_in toggling.
      idle(1);
      pulses(3);
      reset = 1'b1;
      pulses(20);
      c_clk = 1'b0;
      idle(10);
      chk("open_window_no_valid", 32'(n_valid), 32'd0);
      window("after_open", 30, 32'h0000_0030, 1'b0, 8'h30, 1'b0);

      // 1000-cycle window, 10-cycle input period.
      window("w100", 100, 32'h0000_0100, 1'b0, 8'h99, 1'b1);

      // Saturation of the 2-digit instance, then recovery.
      window("w150", 150, 32'h0000_0150, 1'b0, 8'h99, 1'b1);
      window("w7",   7,   32'h0000_0007, 1'b0, 8'h07, 1'b0);

      // Carry through three digits.
      window("w1000", 1000, 32'h0000_1000, 1'b0, 8'h99, 1'b1);

      // Edge seen in the same cycle as the gate closing is counted.
      idle(1);
      c_clk = 1'b1;
      pulses(41);
      sig_in = 1'b1;
      idle(2);
      c_clk = 1'b0;
      wait_result("edge_at_fall", 32'h0000_0042, 1'b0, 8'h42, 1'b0);
      idle(3);
      sig_in = 1'b0;
      idle(10);

      // Edge seen one cycle after the gate closes is not counted.
      idle(1);
      c_clk = 1'b1;
      pulses(41);
      sig_in = 1'b1;
      idle(1);
      c_clk = 1'b0;
      wait_result("edge_after_fall", 32'h0000_0041, 1'b0, 8'h41, 1'b0);
      idle(3);
      sig_in = 1'b0;
      idle(10);

      // Reset mid-window: outputs clear immediately, partial count dropped.
      nv = n_valid;
      idle(1);
      c_clk = 1'b1;
      pulses(20);
      #2 reset = 1'b0;
      #1;
      chk("midrst_freq8",  freq8,       32'd0);
      chk("midrst_ovf8",   32'(ovf8),   32'd0);
      chk("midrst_valid8", 32'(valid8), 32'd0);
      chk("midrst_freq2",  32'(freq2),  32'd0);
      idle(3);
      reset = 1'b1;
      pulses(10);
      c_clk = 1'b0;
      idle(10);
      chk("midrst_no_valid", 32'(n_valid - nv), 32'd0);
      window("after_midrst", 5, 32'h0000_0005, 1'b0, 8'h05, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
